// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake, flush and occupancy.
// SKID=1 gives a two-entry skid buffer with registered In_ready; SKID=0 a single entry.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SKID      = 1'b1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] In_data,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Out_data,
    input  logic             Flush,
    output logic [1:0]       Count
);

    logic w_in_fire;
    logic w_out_fire;

    assign w_in_fire  = In_valid & In_ready;
    assign w_out_fire = Out_valid & Out_ready;

    generate
        if (SKID) begin : g_skid
            // State encoding doubles as the occupancy count.
            localparam logic [1:0] S_EMPTY = 2'd0;
            localparam logic [1:0] S_FULL  = 2'd1;
            localparam logic [1:0] S_BOTH  = 2'd2;

            logic [1:0]       r_state;
            logic [1:0]       w_state_nxt;
            logic [WIDTH-1:0] r_main;
            logic [WIDTH-1:0] r_skid;
            logic             r_in_ready;
            logic             w_ld_main_in;
            logic             w_ld_main_skid;
            logic             w_ld_skid;

            always_comb begin
                w_state_nxt    = r_state;
                w_ld_main_in   = 1'b0;
                w_ld_main_skid = 1'b0;
                w_ld_skid      = 1'b0;
                case (r_state)
                    S_EMPTY: begin
                        if (w_in_fire) begin
                            w_state_nxt  = S_FULL;
                            w_ld_main_in = 1'b1;
                        end
                    end
                    S_FULL: begin
                        if (w_in_fire && w_out_fire) begin
                            w_ld_main_in = 1'b1;
                        end else if (w_in_fire) begin
                            w_state_nxt = S_BOTH;
                            w_ld_skid   = 1'b1;
                        end else if (w_out_fire) begin
                            w_state_nxt = S_EMPTY;
                        end
                    end
                    S_BOTH: begin
                        if (w_out_fire) begin
                            w_state_nxt    = S_FULL;
                            w_ld_main_skid = 1'b1;
                        end
                    end
                    default: w_state_nxt = S_EMPTY;
                endcase
                // Squash wins over everything; data registers keep their contents.
                if (Flush) begin
                    w_state_nxt    = S_EMPTY;
                    w_ld_main_in   = 1'b0;
                    w_ld_main_skid = 1'b0;
                    w_ld_skid      = 1'b0;
                end
            end

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_state    <= S_EMPTY;
                    r_in_ready <= 1'b1;
                end else begin
                    r_state    <= w_state_nxt;
                    r_in_ready <= (w_state_nxt != S_BOTH);
                end
            end

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_main <= RESET_VAL;
                    r_skid <= RESET_VAL;
                end else begin
                    if (w_ld_main_in) begin
                        r_main <= In_data;
                    end else if (w_ld_main_skid) begin
                        r_main <= r_skid;
                    end
                    if (w_ld_skid) begin
                        r_skid <= In_data;
                    end
                end
            end

            assign In_ready  = r_in_ready;
            assign Out_valid = (r_state != S_EMPTY);
            assign Out_data  = r_main;
            assign Count     = r_state;
        end else begin : g_noskid
            logic [WIDTH-1:0] r_main;
            logic             r_valid;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_valid <= 1'b0;
                end else if (Flush) begin
                    r_valid <= 1'b0;
                end else if (w_in_fire) begin
                    r_valid <= 1'b1;
                end else if (w_out_fire) begin
                    r_valid <= 1'b0;
                end
            end

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_main <= RESET_VAL;
                end else if (w_in_fire && !Flush) begin
                    r_main <= In_data;
                end
            end

            assign In_ready  = ~r_valid | Out_ready;
            assign Out_valid = r_valid;
            assign Out_data  = r_main;
            assign Count     = {1'b0, r_valid};
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one skid instance (8-bit) and one single-entry
// instance (16-bit), each with an expected-value queue drained by a monitor.
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst_n;

    logic        a_iv, a_ir, a_ov, a_or, a_fl;
    logic [7:0]  a_id, a_od;
    logic [1:0]  a_cnt;

    logic        b_iv, b_ir, b_ov, b_or, b_fl;
    logic [15:0] b_id, b_od;
    logic [1:0]  b_cnt;

    logic [7:0]  qa[$];
    logic [15:0] qb[$];

    int n_chk  = 0;
    int n_fail = 0;
    int a_deliv = 0;
    int b_deliv = 0;

    pipe_stage_reg #(.WIDTH(8), .RESET_VAL(8'h00), .SKID(1'b1)) u_a (
        .CLK(clk), .RST_N(rst_n),
        .In_valid(a_iv), .In_ready(a_ir), .In_data(a_id),
        .Out_valid(a_ov), .Out_ready(a_or), .Out_data(a_od),
        .Flush(a_fl), .Count(a_cnt)
    );

    pipe_stage_reg #(.WIDTH(16), .RESET_VAL(16'h0000), .SKID(1'b0)) u_b (
        .CLK(clk), .RST_N(rst_n),
        .In_valid(b_iv), .In_ready(b_ir), .In_data(b_id),
        .Out_valid(b_ov), .Out_ready(b_or), .Out_data(b_od),
        .Flush(b_fl), .Count(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Record accepted words (issued by the directed stimulus below) as expected output.
    always @(negedge clk) begin
        if (rst_n && a_iv && a_ir && !a_fl) qa.push_back(a_id);
        if (rst_n && b_iv && b_ir && !b_fl) qb.push_back(b_id);
    end

    // Monitors: compare every delivered word against the queue head.
    always @(negedge clk) begin
        if (rst_n && a_ov && a_or) begin
            if (qa.size() == 0) chk("a_unexpected_out", 32'(a_od), 32'hFFFF_FFFF);
            else chk("a_out_data", 32'(a_od), 32'(qa.pop_front()));
            a_deliv++;
        end
        if (rst_n && b_ov && b_or) begin
            if (qb.size() == 0) chk("b_unexpected_out", 32'(b_od), 32'hFFFF_FFFF);
            else chk("b_out_data", 32'(b_od), 32'(qb.pop_front()));
            b_deliv++;
        end
    end

    initial begin
        rst_n = 1'b0;
        a_iv = 0; a_or = 0; a_fl = 0; a_id = 8'h00;
        b_iv = 0; b_or = 0; b_fl = 0; b_id = 16'h0000;
        step(); step();
        chk("rst_a_ov", 32'(a_ov), 0);
        chk("rst_a_cnt", 32'(a_cnt), 0);
        chk("rst_a_od", 32'(a_od), 0);
        chk("rst_a_ir", 32'(a_ir), 1);
        chk("rst_b_ov", 32'(b_ov), 0);
        chk("rst_b_od", 32'(b_od), 0);
        rst_n = 1'b1;
        step();

        // Streaming 0x01..0x10 with Out_ready high: no bubbles, one-cycle latency.
        a_or = 1;
        for (int i = 1; i <= 16; i++) begin
            a_iv = 1; a_id = 8'(i);
            step();
            chk("stream_od", 32'(a_od), 32'(i));
            chk("stream_ov", 32'(a_ov), 1);
            chk("stream_cnt", 32'(a_cnt), 1);
            chk("stream_ir", 32'(a_ir), 1);
        end
        a_iv = 0;
        step();
        chk("stream_end_cnt", 32'(a_cnt), 0);

        // Backpressure: A1 held, A2 in skid, A3 stalls.
        a_or = 0;
        a_iv = 1; a_id = 8'hA1; step();
        chk("bp_cnt1", 32'(a_cnt), 1);
        chk("bp_ir1", 32'(a_ir), 1);
        a_id = 8'hA2; step();
        chk("bp_cnt2", 32'(a_cnt), 2);
        chk("bp_ir2", 32'(a_ir), 0);
        chk("bp_od2", 32'(a_od), 32'hA1);
        a_id = 8'hA3; step();
        chk("bp_stall_cnt", 32'(a_cnt), 2);
        chk("bp_stall_od", 32'(a_od), 32'hA1);
        step();
        chk("bp_stall2_od", 32'(a_od), 32'hA1);
        a_or = 1; step();
        chk("bp_drain_od", 32'(a_od), 32'hA2);
        chk("bp_drain_cnt", 32'(a_cnt), 1);
        chk("bp_drain_ir", 32'(a_ir), 1);
        step();
        chk("bp_a3_od", 32'(a_od), 32'hA3);
        a_iv = 0; step();
        chk("bp_empty_cnt", 32'(a_cnt), 0);

        // Simultaneous in/out while FULL.
        a_or = 0; a_iv = 1; a_id = 8'h3C; step();
        a_id = 8'h4D; a_or = 1; step();
        chk("sim_od", 32'(a_od), 32'h4D);
        chk("sim_cnt", 32'(a_cnt), 1);
        a_iv = 0; a_or = 0; step();
        chk("sim_hold_od", 32'(a_od), 32'h4D);
        a_or = 1; step();

        // Flush with two entries held and 0x77 offered.
        a_or = 0; a_iv = 1; a_id = 8'h55; step();
        a_id = 8'h66; step();
        chk("fl_cnt2", 32'(a_cnt), 2);
        a_id = 8'h77; a_fl = 1; step();
        chk("fl_ov", 32'(a_ov), 0);
        chk("fl_cnt", 32'(a_cnt), 0);
        chk("fl_ir", 32'(a_ir), 1);
        qa.delete();
        // Flush while FULL with an accepted input: input discarded, main holds.
        a_fl = 0; a_id = 8'h88; step();
        a_id = 8'h99; a_fl = 1; step();
        chk("fl2_ov", 32'(a_ov), 0);
        chk("fl2_od_hold", 32'(a_od), 32'h88);
        qa.delete();
        a_fl = 0; a_or = 1; a_id = 8'h12; step();
        chk("post_fl_od", 32'(a_od), 32'h12);
        a_iv = 0; step();

        // Asynchronous reset mid-stream with two entries held.
        a_or = 0; a_iv = 1; a_id = 8'h21; step();
        a_id = 8'h22; step();
        chk("rs_cnt2", 32'(a_cnt), 2);
        #2 rst_n = 0;
        #1;
        chk("rs_ov", 32'(a_ov), 0);
        chk("rs_cnt", 32'(a_cnt), 0);
        chk("rs_od", 32'(a_od), 0);
        qa.delete();
        a_iv = 0;
        step();
        rst_n = 1;
        chk("rs_ir", 32'(a_ir), 1);
        step();

        // Single-entry, 16-bit: combinational In_ready.
        b_or = 0; b_iv = 1; b_id = 16'hBEEF; step();
        chk("b_ov", 32'(b_ov), 1);
        chk("b_od", 32'(b_od), 32'hBEEF);
        chk("b_ir_blocked", 32'(b_ir), 0);
        b_id = 16'hCAFE; b_or = 1; #1;
        chk("b_ir_comb", 32'(b_ir), 1);
        step();
        chk("b_od_cafe", 32'(b_od), 32'hCAFE);
        chk("b_cnt1", 32'(b_cnt), 1);
        b_iv = 0; step();
        chk("b_ov0", 32'(b_ov), 0);
        chk("b_cnt0", 32'(b_cnt), 0);
        b_iv = 1; b_id = 16'h1111; step();
        chk("b_s1", 32'(b_od), 32'h1111);
        b_id = 16'h2222; step();
        chk("b_s2", 32'(b_od), 32'h2222);
        b_id = 16'h3333; step();
        chk("b_s3", 32'(b_od), 32'h3333);
        b_iv = 0; step();
        // Flush coinciding with delivery of 0x4444 and offer of 0x5555.
        b_or = 0; b_iv = 1; b_id = 16'h4444; step();
        b_id = 16'h5555; b_or = 1; b_fl = 1; step();
        chk("b_fl_ov", 32'(b_ov), 0);
        chk("b_fl_cnt", 32'(b_cnt), 0);
        chk("b_fl_od_hold", 32'(b_od), 32'h4444);
        b_fl = 0; b_iv = 0; qb.delete();
        step(); step();

        chk("a_delivered", 32'(a_deliv), 22);
        chk("b_delivered", 32'(b_deliv), 6);
        chk("a_queue_left", 32'(qa.size()), 0);
        chk("b_queue_left", 32'(qb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised elastic pipeline-stage register, the successor to the plain enable register between processor pipeline stages. It generalises data width and adds a valid/ready handshake, an optional 2-entry skid buffer for full throughput with registered ready, synchronous flush for branch/hazard squash, and an occupancy output. It sits between adjacent stages (IF/ID, ID/EX, EX/WB) of the 8-bit pipelined core.

Parameters:
WIDTH, 8, payload width in bits (>=1)
RESET_VAL, 0, value of the data registers after reset (WIDTH bits)
SKID, 1, 1 = two-entry skid buffer with registered In_ready; 0 = single entry with combinational In_ready

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous reset, active-low
In_valid  input  1  upstream payload valid
In_ready  output  1  stage can accept this cycle
In_data  input  WIDTH  upstream payload
Out_valid  output  1  payload available downstream
Out_ready  input  1  downstream accepts this cycle
Out_data  output  WIDTH  payload to downstream
Flush  input  1  synchronous squash of all held entries
Count  output  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Single clock CLK; reset asynchronous, active-low on RST_N; all other control is synchronous.
- in_fire = In_valid & In_ready; out_fire = Out_valid & Out_ready.
- Reset (RST_N=0, any time incl. mid-transfer): state EMPTY, Out_valid=0, Count=0, main/skid data = RESET_VAL, In_ready=1. Held entries are lost.
- SKID=1, states EMPTY / FULL / BOTH; Out_data = main reg; Out_valid = (state!=EMPTY); In_ready registered, =1 in EMPTY/FULL, 0 in BOTH.
  - EMPTY: in_fire -> FULL, main<=In_data.
  - FULL: in_fire & out_fire -> FULL, main<=In_data; in_fire only -> BOTH, skid<=In_data; out_fire only -> EMPTY.
  - BOTH: out_fire -> FULL, main<=skid; no input accepted.
  - Count: EMPTY=0, FULL=1, BOTH=2.
- SKID=0: single main reg; In_ready = ~Out_valid | Out_ready (combinational); in_fire loads main and sets Out_valid; out_fire without in_fire clears Out_valid; Count = Out_valid.
- Latency: accepted payload appears on Out_data with Out_valid the cycle after in_fire (1 cycle). Sustained throughput 1 word/cycle while Out_ready=1, both modes.
- Ordering strictly FIFO; no payload duplicated or dropped except by Flush/reset.
- Flush=1 at edge: highest priority; next state EMPTY, Out_valid=0, Count=0, In_ready=1. Any payload accepted in the same cycle (in_fire) is discarded; any out_fire in that cycle counts as delivered. Data regs hold their values (not cleared).
- Out_data is stable while Out_valid=1 & Out_ready=0. Out_data when Out_valid=0 is don't-care for consumers but must equal last loaded value or RESET_VAL.
- In_valid with In_ready=0 has no effect; upstream must hold In_data.

Test Plan:
- Reset: RST_N low mid-stream with Count=2 -> immediately Out_valid=0, Count=0, Out_data=RESET_VAL (0x00); In_ready=1 after release.
- Streaming: In_valid=1, Out_ready=1, data 0x01..0x10 on consecutive cycles -> Out_data 0x01..0x10 one cycle later, no bubbles, Count stays 1.
- Backpressure (SKID=1): send 0xA1,0xA2,0xA3 with Out_ready=0 -> 0xA1 held on Out_data, Count=2, In_ready=0 after 0xA2, 0xA3 stalls; raise Out_ready -> outputs 0xA1,0xA2,0xA3 in order.
- Flush: Count=2 (0x55,0x66), assert Flush with In_valid=1 data 0x77 -> next cycle Out_valid=0, Count=0; 0x77 never appears downstream.
- Simultaneous in/out in FULL: main=0x3C, in 0x4D with Out_ready=1 -> 0x3C consumed, Out_data=0x4D next cycle, Count=1.
- SKID=0, WIDTH=16: Out_ready=0 with Out_valid=1 -> In_ready=0 same cycle; Out_ready=1 -> In_ready=1 combinationally, 0xBEEF passes with 1-cycle latency.
